// File: rtl/gaplus_ram_arbiter_if.sv
// gaplus_ram_arbiter_if
//   Bundles the two requester ports, the RAM CL0 port and BUSY so the
//   arbiter and its environment connect through a single port.
//   slave  : arbiter side (consumes requests and ROUT, drives grants and RAM)
//   master : environment side (requesters plus RAM model)
interface gaplus_ram_arbiter_if #(
  parameter int AW = 11,
  parameter int DW = 8
);
  // requester side
  logic          REQ0, REQ1;
  logic          WR0,  WR1;
  logic [AW-1:0] ADRS0, ADRS1;
  logic [DW-1:0] IN0,  IN1;
  logic [DW-1:0] OUT0, OUT1;
  logic          ACK0, ACK1;
  // RAM side
  logic [AW-1:0] RADRS;
  logic [DW-1:0] RIN;
  logic          RWR;
  logic [DW-1:0] ROUT;
  // status
  logic          BUSY;

  modport slave (
    input  REQ0, REQ1, WR0, WR1, ADRS0, ADRS1, IN0, IN1, ROUT,
    output OUT0, OUT1, ACK0, ACK1, RADRS, RIN, RWR, BUSY
  );

  modport master (
    output REQ0, REQ1, WR0, WR1, ADRS0, ADRS1, IN0, IN1, ROUT,
    input  OUT0, OUT1, ACK0, ACK1, RADRS, RIN, RWR, BUSY
  );
endinterface

// File: rtl/gaplus_ram_arbiter.sv
// gaplus_ram_arbiter
//   Round-robin arbiter/sequencer for one write-capable port of a 2^AW x DW
//   synchronous RAM shared by two requesters. Each access takes 3 cycles:
//   IDLE (grant, drive RAM port) -> ACC (RAM acts) -> DONE (ACK + read data).
//   Optional feature macro RAMCLR_EN: after every reset, fill the whole RAM
//   with CLRVAL (BUSY high meanwhile) before serving requests.
// Ports:
//   CL     clock (shared with the RAM port)
//   RST_N  asynchronous active-low reset
//   bus    gaplus_ram_arbiter_if.slave: REQn/WRn/ADRSn/INn in, OUTn/ACKn out,
//          RADRS/RIN/RWR out, ROUT in, BUSY out. All outputs registered.
module gaplus_ram_arbiter #(
  parameter int            AW     = 11,
  parameter int            DW     = 8,
  parameter logic [DW-1:0] CLRVAL = '0
) (
  input  logic                 CL,
  input  logic                 RST_N,
  gaplus_ram_arbiter_if.slave  bus
);

`ifdef RAMCLR_EN
  typedef enum logic [1:0] {CLEAR, IDLE, ACC, DONE} state_t;
  localparam state_t RST_ST = CLEAR;
  logic busy_q, busy_d;
`else
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  localparam state_t RST_ST = IDLE;
  logic unused_clrval;
  assign unused_clrval = ^CLRVAL;
`endif

  state_t        state_q, state_d;
  logic          last_q, last_d;   // last granted requester
  logic          gnt_q, gnt_d;     // requester owning the in-flight access
  logic          wr_q, wr_d;       // in-flight access is a write
  logic          rwr_q, rwr_d;
  logic [1:0]    ack_q, ack_d;
  logic [AW-1:0] radrs_q, radrs_d;
  logic [DW-1:0] rin_q, rin_d;
  logic [DW-1:0] out0_q, out0_d, out1_q, out1_d;
  logic [1:0]    elig;
  logic          pick;             // 1 = grant requester 1

  always_ff @(posedge CL or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= RST_ST;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      wr_q    <= 1'b0;
      rwr_q   <= 1'b0;
      ack_q   <= '0;
      radrs_q <= '0;
      rin_q   <= '0;
      out0_q  <= '0;
      out1_q  <= '0;
`ifdef RAMCLR_EN
      busy_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      rwr_q   <= rwr_d;
      ack_q   <= ack_d;
      radrs_q <= radrs_d;
      rin_q   <= rin_d;
      out0_q  <= out0_d;
      out1_q  <= out1_d;
`ifdef RAMCLR_EN
      busy_q  <= busy_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    rwr_d   = 1'b0;
    ack_d   = '0;
    radrs_d = radrs_q;
    rin_d   = rin_q;
    out0_d  = out0_q;
    out1_d  = out1_q;
`ifdef RAMCLR_EN
    busy_d  = busy_q;
`endif
    // A requester whose ACK is showing is finishing; it is not re-granted
    // until one cycle later, which lets the other side win in between.
    elig = {bus.REQ1 & ~ack_q[1], bus.REQ0 & ~ack_q[0]};
    pick = elig[1] & (~elig[0] | ~last_q);

    case (state_q)
`ifdef RAMCLR_EN
      CLEAR: begin
        // RADRS doubles as the fill counter; rwr_q low means nothing issued yet.
        if (rwr_q && (radrs_q == {AW{1'b1}})) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          rwr_d   = 1'b1;
          rin_d   = CLRVAL;
          radrs_d = rwr_q ? radrs_q + AW'(1) : '0;
        end
      end
`endif
      IDLE: begin
        if (|elig) begin
          gnt_d   = pick;
          last_d  = pick;
          radrs_d = pick ? bus.ADRS1 : bus.ADRS0;
          rin_d   = pick ? bus.IN1   : bus.IN0;
          rwr_d   = pick ? bus.WR1   : bus.WR0;
          wr_d    = pick ? bus.WR1   : bus.WR0;
          state_d = ACC;
        end
      end
      ACC: state_d = DONE;
      DONE: begin
        ack_d[gnt_q] = 1'b1;
        if (!wr_q) begin
          if (gnt_q) out1_d = bus.ROUT;
          else       out0_d = bus.ROUT;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.RADRS = radrs_q;
  assign bus.RIN   = rin_q;
  assign bus.RWR   = rwr_q;
  assign bus.ACK0  = ack_q[0];
  assign bus.ACK1  = ack_q[1];
  assign bus.OUT0  = out0_q;
  assign bus.OUT1  = out1_q;
`ifdef RAMCLR_EN
  assign bus.BUSY  = busy_q;
`else
  assign bus.BUSY  = 1'b0;
`endif

endmodule
